// File: rtl/vga_stream_out_if.sv
// Pixel stream link between the upstream loader and vga_stream_out.
// The loader (master) presents a 24-bit RGB word with a write strobe and
// watches the FIFO status flags that the display side (slave) returns.
interface vga_stream_out_if;
    logic [23:0] PIX_IN;
    logic        PIX_WE;
    logic        FIFO_FULL;
    logic        FIFO_EMPTY;

    modport master (
        output PIX_IN,
        output PIX_WE,
        input  FIFO_FULL,
        input  FIFO_EMPTY
    );

    modport slave (
        input  PIX_IN,
        input  PIX_WE,
        output FIFO_FULL,
        output FIFO_EMPTY
    );
endinterface

// File: rtl/vga_stream_out.sv
// vga_stream_out: buffers the loader's RGB stream in a small FIFO, generates
// VGA raster timing and drains one pixel per active pixel slot. All pins are
// registered and change one CLK after the PIX_EN tick they belong to.
// Optional colour-bar generator is compiled only when VGA_TEST_PATTERN_EN is
// defined; the default build ignores TEST_MODE.
module vga_stream_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FIFO_AW  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PIX_EN,
    input  logic              TEST_MODE,
    vga_stream_out_if.slave   pix_if,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              FRAME_START,
    output logic              UNDERFLOW
);

    // Raster boundaries in counter units.
    localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST       = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_FULL   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] CNT_ZERO   = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0] CNT_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW - 1){1'b0}}, 1'b1};

    // Raster state
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;

    // FIFO state
    logic [23:0]        mem_q [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;

    // Registered pins
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic        frame_start_q, frame_start_d;
    logic        underflow_q, underflow_d;

    // Combinational helpers
    logic        active_s;
    logic        hs_low_s;
    logic        vs_low_s;
    logic        full_s;
    logic        empty_s;
    logic        pattern_sel_s;
    logic        pop_s;
    logic        push_s;
    logic        underflow_hit_s;
    logic [23:0] head_s;
    logic [23:0] bar_rgb_s;

`ifdef VGA_TEST_PATTERN_EN
    // Eight vertical bars, left to right: white, yellow, cyan, green,
    // magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic [2:0] bar_idx_s;

    // Bar index scales the horizontal position into eight equal bands.
    always_comb begin
        bar_idx_s = 3'((32'(h_cnt_q) * 32'd8) / 32'(H_ACTIVE));
    end

    assign pattern_sel_s = TEST_MODE;
    assign bar_rgb_s     = bar_colour(bar_idx_s);
`else
    logic test_mode_unused_s;
    assign test_mode_unused_s = TEST_MODE;
    assign pattern_sel_s      = 1'b0;
    assign bar_rgb_s          = 24'h000000;
`endif

    // Decode raster position into active area and sync windows.
    always_comb begin
        active_s = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        hs_low_s = (h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END);
        vs_low_s = (v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END);
    end

    // Advance the raster one slot per PIX_EN, wrapping line then frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (PIX_EN) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 11'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 11'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 11'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // FIFO status and pop/push decisions. A push into a full FIFO is
    // accepted only when the same cycle pops, so occupancy stays at max.
    // An empty FIFO never forwards the incoming word to the pins.
    always_comb begin
        full_s          = (cnt_q == CNT_FULL);
        empty_s         = (cnt_q == CNT_ZERO);
        pop_s           = PIX_EN && active_s && !empty_s && !pattern_sel_s;
        underflow_hit_s = PIX_EN && active_s && empty_s && !pattern_sel_s;
        push_s          = pix_if.PIX_WE && (!full_s || pop_s);
        head_s          = mem_q[rd_ptr_q];
    end

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Next pin values: captured on PIX_EN ticks, held otherwise; FRAME_START
    // is a single-CLK pulse and UNDERFLOW is sticky.
    always_comb begin
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_n_d     = blank_n_q;
        frame_start_d = PIX_EN && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        underflow_d   = underflow_q || underflow_hit_s;
        if (PIX_EN) begin
            hs_d      = !hs_low_s;
            vs_d      = !vs_low_s;
            blank_n_d = active_s;
            if (!active_s) begin
                rgb_d = 24'h000000;
            end else if (pattern_sel_s) begin
                rgb_d = bar_rgb_s;
            end else if (!empty_s) begin
                rgb_d = head_s;
            end else begin
                rgb_d = 24'h000000;
            end
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Raster, FIFO control and pin registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_cnt_q       <= 11'd0;
            v_cnt_q       <= 11'd0;
            wr_ptr_q      <= {FIFO_AW{1'b0}};
            rd_ptr_q      <= {FIFO_AW{1'b0}};
            cnt_q         <= CNT_ZERO;
            rgb_q         <= 24'h000000;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (!RESET && push_s) begin
            mem_q[wr_ptr_q] <= pix_if.PIX_IN;
        end
    end

    assign pix_if.FIFO_FULL  = full_s;
    assign pix_if.FIFO_EMPTY = empty_s;
    assign VGA_R             = rgb_q[23:16];
    assign VGA_G             = rgb_q[15:8];
    assign VGA_B             = rgb_q[7:0];
    assign VGA_HS            = hs_q;
    assign VGA_VS            = vs_q;
    assign VGA_BLANK_N       = blank_n_q;
    assign FRAME_START       = frame_start_q;
    assign UNDERFLOW         = underflow_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a small 8x5 raster (4x2 active).
module tb_vga_stream_out;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PIX_EN;
    logic       TEST_MODE;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, FRAME_START, UNDERFLOW;

    int total = 0;
    int bad   = 0;

    vga_stream_out_if pif ();

    vga_stream_out #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FIFO_AW(4)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PIX_EN     (PIX_EN),
        .TEST_MODE  (TEST_MODE),
        .pix_if     (pif.slave),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .FRAME_START(FRAME_START),
        .UNDERFLOW  (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        int          h;
        int          v;
        int          pop_idx;
        logic        act;
        logic        uf_exp;
        logic [23:0] exp_rgb;
        logic [23:0] exp_q [0:16];

        RESET      = 1'b1;
        PIX_EN     = 1'b0;
        TEST_MODE  = 1'b0;
        pif.PIX_IN = 24'h000000;
        pif.PIX_WE = 1'b0;

        // ---- reset state ----
        step();
        step();
        RESET = 1'b0;
        chk("rst_rgb",   rgb(),           32'h0);
        chk("rst_hs",    32'(VGA_HS),      32'd1);
        chk("rst_vs",    32'(VGA_VS),      32'd1);
        chk("rst_blank", 32'(VGA_BLANK_N), 32'd0);
        chk("rst_fs",    32'(FRAME_START), 32'd0);
        chk("rst_uf",    32'(UNDERFLOW),   32'd0);
        chk("rst_empty", 32'(pif.FIFO_EMPTY), 32'd1);
        chk("rst_full",  32'(pif.FIFO_FULL),  32'd0);

        // ---- preload 1..4 then run one frame plus one slot ----
        for (int i = 1; i <= 4; i++) begin
            pif.PIX_IN = 24'(i);
            pif.PIX_WE = 1'b1;
            step();
        end
        pif.PIX_WE = 1'b0;
        chk("pre_empty", 32'(pif.FIFO_EMPTY), 32'd0);
        chk("pre_full",  32'(pif.FIFO_FULL),  32'd0);

        PIX_EN = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            step();
            h   = k % 8;
            v   = (k / 8) % 5;
            act = (h < 4) && (v < 2);
            chk("t_rgb",   rgb(), (k < 4) ? 32'(k + 1) : 32'h0);
            chk("t_blank", 32'(VGA_BLANK_N), act ? 32'd1 : 32'd0);
            chk("t_hs",    32'(VGA_HS), (h == 5 || h == 6) ? 32'd0 : 32'd1);
            chk("t_vs",    32'(VGA_VS), (v == 3) ? 32'd0 : 32'd1);
            chk("t_fs",    32'(FRAME_START), (k % 40 == 0) ? 32'd1 : 32'd0);
            chk("t_uf",    32'(UNDERFLOW), (k >= 8) ? 32'd1 : 32'd0);
            chk("t_empty", 32'(pif.FIFO_EMPTY), (k >= 3) ? 32'd1 : 32'd0);
        end

        // ---- outputs hold while PIX_EN is low; FRAME_START drops ----
        PIX_EN = 1'b0;
        step();
        chk("hold_fs",    32'(FRAME_START), 32'd0);
        chk("hold_blank", 32'(VGA_BLANK_N), 32'd1);
        chk("hold_uf",    32'(UNDERFLOW),   32'd1);
        step();
        chk("hold_blank2", 32'(VGA_BLANK_N), 32'd1);
        chk("hold_hs",     32'(VGA_HS),      32'd1);

        // ---- 17 writes into an idle FIFO ----
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("rst2_uf", 32'(UNDERFLOW), 32'd0);
        for (int i = 1; i <= 17; i++) begin
            pif.PIX_IN = 24'h000100 + 24'(i);
            pif.PIX_WE = 1'b1;
            step();
            if (i == 15) chk("full_at15", 32'(pif.FIFO_FULL), 32'd0);
            if (i >= 16) chk("full_at16p", 32'(pif.FIFO_FULL), 32'd1);
        end
        for (int i = 0; i < 16; i++) exp_q[i] = 24'h000101 + 24'(i);
        exp_q[16] = 24'hABCDEF;

        // ---- full FIFO: push and pop together, then drain ----
        pif.PIX_IN = 24'hABCDEF;
        pif.PIX_WE = 1'b1;
        PIX_EN     = 1'b1;
        pop_idx    = 0;
        uf_exp     = 1'b0;
        for (int k = 0; k < 88; k++) begin
            step();
            if (k == 0) pif.PIX_WE = 1'b0;
            h   = k % 8;
            v   = (k / 8) % 5;
            act = (h < 4) && (v < 2);
            exp_rgb = 24'h000000;
            if (act) begin
                if (pop_idx < 17) begin
                    exp_rgb = exp_q[pop_idx];
                    pop_idx++;
                end else begin
                    uf_exp = 1'b1;
                end
            end
            chk("drain_rgb", rgb(), 32'(exp_rgb));
            chk("drain_uf",  32'(UNDERFLOW), 32'(uf_exp));
            if (k == 0) chk("pp_full", 32'(pif.FIFO_FULL), 32'd1);
            if (k == 1) chk("pp_full_drop", 32'(pif.FIFO_FULL), 32'd0);
        end
        chk("drain_empty", 32'(pif.FIFO_EMPTY), 32'd1);

        // ---- reset mid-line at h_cnt=2 with 5 entries buffered ----
        step();
        step();
        PIX_EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pif.PIX_IN = 24'h00AA00 + 24'(i);
            pif.PIX_WE = 1'b1;
            step();
        end
        pif.PIX_WE = 1'b0;
        chk("mid_pre_empty", 32'(pif.FIFO_EMPTY), 32'd0);
        chk("mid_pre_uf",    32'(UNDERFLOW),      32'd1);
        RESET  = 1'b1;
        PIX_EN = 1'b1;
        step();
        RESET = 1'b0;
        chk("mid_empty", 32'(pif.FIFO_EMPTY), 32'd1);
        chk("mid_hs",    32'(VGA_HS),      32'd1);
        chk("mid_vs",    32'(VGA_VS),      32'd1);
        chk("mid_blank", 32'(VGA_BLANK_N), 32'd0);
        chk("mid_uf",    32'(UNDERFLOW),   32'd0);
        chk("mid_fs",    32'(FRAME_START), 32'd0);
        chk("mid_rgb",   rgb(),            32'h0);
        step();
        chk("post_fs",    32'(FRAME_START), 32'd1);
        chk("post_blank", 32'(VGA_BLANK_N), 32'd1);
        chk("post_rgb",   rgb(),            32'h0);
        chk("post_uf",    32'(UNDERFLOW),   32'd1);
        step();
        chk("post_fs2",   32'(FRAME_START), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_stream_out.md
Name: vga_stream_out

Overview:
- Downstream consumer of the pixel loader's 24-bit RGB pixel stream.
- Buffers incoming pixels in a small synchronous FIFO.
- Generates VGA raster timing (HS/VS/blank) and drains one pixel per active pixel slot.
- Drives the board DAC pins and pulses FRAME_START so the upstream loader can restart its address sweep each frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel slots)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  reset, synchronous, active-high
- PIX_EN  in  1  pixel-slot tick; raster advances only on cycles with PIX_EN=1
- PIX_IN  in  24  pixel from loader, {R[23:16],G[15:8],B[7:0]}
- PIX_WE  in  1  write strobe for PIX_IN
- TEST_MODE  in  1  selects colour bars (used only with VGA_TEST_PATTERN_EN)
- FIFO_FULL  out  1  FIFO holds 2**FIFO_AW entries
- FIFO_EMPTY  out  1  FIFO holds 0 entries
- VGA_R / VGA_G / VGA_B  out  8 each  colour outputs
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  1 = active video
- FRAME_START  out  1  one-CLK pulse at raster position (0,0)
- UNDERFLOW  out  1  sticky: a pixel was needed in the active area while the FIFO was empty

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Raster counters:
  - h_cnt counts 0..H_TOTAL-1 and increments on PIX_EN.
  - On wrap to 0, v_cnt increments (0..V_TOTAL-1), then wraps to 0.
  - Counters are 11 bits and hold when PIX_EN=0.
- Active area: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- HS low while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; VS uses the same rule on v_cnt.
- Output timing:
  - On a PIX_EN cycle, the outputs for the current (h_cnt,v_cnt) are registered and appear on the next CLK.
  - Latency: 1 CLK from PIX_EN to pins.
  - Outputs hold between ticks.
- Pixel read: in a PIX_EN cycle inside the active area:
  - If FIFO is non-empty: pop the head and drive it to VGA_R/G/B.
  - If FIFO is empty: drive 0,0,0 and set UNDERFLOW.
  - Outside the active area: no pop, RGB = 0, VGA_BLANK_N = 0.
- FIFO write: the entry is written when PIX_WE=1 and FIFO_FULL=0. PIX_WE while full is dropped and state is unchanged.
- Simultaneous pop and push:
  - When full: both occur; count stays at max.
  - When empty: push only; the pop sees empty and takes the underflow path (no fall-through).
- Occupancy counter: FIFO_AW+1 bits; FIFO_FULL and FIFO_EMPTY are decoded combinationally from it.
- FRAME_START: 1 for exactly one CLK, on the PIX_EN cycle where h_cnt=0 and v_cnt=0.
- Reset values, taking effect on the next edge with RESET=1 (including mid-frame):
  - h_cnt = v_cnt = 0, FIFO pointers and count = 0.
  - FIFO_EMPTY=1, FIFO_FULL=0.
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - FRAME_START=0, UNDERFLOW=0.
- UNDERFLOW clears only on RESET.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- With the macro defined and TEST_MODE=1:
  - Active-area RGB = 8 vertical colour bars, index = h_cnt*8/H_ACTIVE.
  - Colours: white, yellow, cyan, green, magenta, red, blue, black.
  - FIFO is not popped and UNDERFLOW is not set; sync and blank timing are unchanged.
- Without the macro: TEST_MODE is ignored and no bar logic is compiled.

Test Plan:
- Small-raster timing (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1), PIX_EN=1 every cycle:
  - HS low for h_cnt 5..6; VS low on line 3.
  - FRAME_START pulse every 40 CLK.
  - BLANK_N high for 4 of every 8 slots on lines 0..1.
- Preload FIFO with 0x000001..0x000004, then run the raster:
  - First active line outputs 0x000001..0x000004 in order, each one CLK after its PIX_EN.
  - FIFO_EMPTY=1 afterwards.
- 17 writes with no reads:
  - FIFO_FULL=1 after the 16th write.
  - The 17th value is dropped; 16 pops return the first 16 values.
- Empty FIFO at the start of active video:
  - RGB=0 and UNDERFLOW=1, remaining 1 through later frames until RESET.
- Full FIFO with PIX_WE=1 and an active pop on the same cycle:
  - Count stays 16, the head advances, and the new value lands at the tail.
- Assert RESET for one CLK mid-line (h_cnt=2, FIFO count=5):
  - Next cycle: counters 0, FIFO_EMPTY=1, HS=VS=1, BLANK_N=0, UNDERFLOW=0.
  - FRAME_START fires on the first PIX_EN after reset release.
